// File: rtl/uart_pkg.sv
// Shared constants for the UART frame controller: header byte, error codes
// and the frame-parser state encoding.
package uart_pkg;

    localparam logic [7:0] FRAME_HDR = 8'h55;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;
    localparam logic [1:0] ERR_TO   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CHK  = 3'd4
    } frame_state_t;

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte timeout counter: counts while enabled, clears on i_clr, flags
// expiry on the cycle the count reaches LIMIT-1 (a same-cycle clear wins).
module uart_byte_timer #(
    parameter int LIMIT = 75000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expire = en & ~clr & (r_cnt == LAST);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame parser behind the UART receiver: 0x55, CMD, LEN, payload, XOR checksum.
// Buffers the payload and reports good frames or aborts to the command decoder.
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 36000000,
    parameter int UART_BPS     = 9600,
    parameter int MAX_LEN      = 16,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         byte_valid,
    input  logic [7:0]                   byte_data,
    output logic                         frame_valid,
    output logic [7:0]                   frame_cmd,
    output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
    input  logic [$clog2(MAX_LEN)-1:0]   rd_addr,
    output logic [7:0]                   rd_data,
    output logic                         frame_err,
    output logic [1:0]                   err_code,
    output logic                         busy,
    output logic [2:0]                   dbg_state
);

    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int AW      = $clog2(MAX_LEN);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;

    frame_state_t   r_state;
    logic           r_bv_d;
    logic [7:0]     r_cmd;
    logic [LW-1:0]  r_len;
    logic [AW-1:0]  r_idx;
    logic [7:0]     r_chk;
    logic           r_frame_valid;
    logic           r_frame_err;
    logic [7:0]     r_frame_cmd;
    logic [LW-1:0]  r_frame_len;
    logic [1:0]     r_err_code;
    logic [7:0]     r_rd_data;
    logic [7:0]     r_buf [MAX_LEN];
    logic           w_stb;
    logic           w_expire;

    // The receiver's done flag can stay high for many cycles; only its rising edge is a byte.
    assign w_stb = byte_valid & ~r_bv_d;

    uart_byte_timer #(
        .LIMIT (TIMEOUT_BITS * BPS_CNT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_stb | (r_state == ST_IDLE)),
        .en     (r_state != ST_IDLE),
        .expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_bv_d        <= 1'b0;
            r_cmd         <= '0;
            r_len         <= '0;
            r_idx         <= '0;
            r_chk         <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_cmd   <= '0;
            r_frame_len   <= '0;
            r_err_code    <= ERR_NONE;
        end else begin
            r_bv_d        <= byte_valid;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            if (w_stb) begin
                case (r_state)
                    ST_IDLE: begin
                        if (byte_data == FRAME_HDR) r_state <= ST_CMD;
                    end
                    ST_CMD: begin
                        r_cmd   <= byte_data;
                        r_chk   <= byte_data;
                        r_state <= ST_LEN;
                    end
                    ST_LEN: begin
                        if (byte_data > 8'(MAX_LEN)) begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= ERR_LEN;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_len   <= byte_data[LW-1:0];
                            r_chk   <= r_chk ^ byte_data;
                            r_idx   <= '0;
                            r_state <= (byte_data == 8'd0) ? ST_CHK : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        r_chk <= r_chk ^ byte_data;
                        r_idx <= r_idx + 1'b1;
                        if (LW'(r_idx) == r_len - LW'(1)) r_state <= ST_CHK;
                    end
                    ST_CHK: begin
                        if (byte_data == r_chk) begin
                            r_frame_valid <= 1'b1;
                            r_frame_cmd   <= r_cmd;
                            r_frame_len   <= r_len;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= ERR_CHK;
                        end
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (w_expire) begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_TO;
                r_state     <= ST_IDLE;
            end
        end
    end

    // Payload storage is not reset; a new frame simply overwrites it.
    always_ff @(posedge clk) begin
        if (w_stb && (r_state == ST_DATA)) r_buf[r_idx] <= byte_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rd_data <= '0;
        else     r_rd_data <= r_buf[rd_addr];
    end

    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign frame_cmd   = r_frame_cmd;
    assign frame_len   = r_frame_len;
    assign err_code    = r_err_code;
    assign rd_data     = r_rd_data;
    assign busy        = (r_state != ST_IDLE);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl, run with a 10-clock bit period so the
// timeout (20 bits) expires 200 clocks after the last byte strobe.
module tb_uart_frame_ctrl;

    logic       clk;
    logic       rst;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_valid;
    logic [7:0] frame_cmd;
    logic [4:0] frame_len;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int n_overlap = 0;
    logic s_fv, s_fe;

    uart_frame_ctrl #(
        .CLK_FREQ     (96000),
        .UART_BPS     (9600),
        .MAX_LEN      (16),
        .TIMEOUT_BITS (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .frame_valid (frame_valid),
        .frame_cmd   (frame_cmd),
        .frame_len   (frame_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid && frame_err) n_overlap++;
    end

    // Raise byte_valid at a negedge, sample the flags one clock after the strobe edge.
    task automatic send_byte(input logic [7:0] d, input int hold);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = d;
        @(negedge clk);
        s_fv = frame_valid;
        s_fe = frame_err;
        repeat (hold - 1) @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic read_byte(input logic [3:0] a, input logic [7:0] exp, input string name);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        n_checks++;
        if (rd_data !== exp) $display("FAIL %s: rd_data=%h expected %h", name, rd_data, exp);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; rd_addr = 4'd0;
        repeat (3) @(negedge clk);
        n_checks++; if (frame_valid !== 1'b0) $display("FAIL rst_fv: %b expected 0", frame_valid); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL rst_fe: %b expected 0", frame_err); else n_pass++;
        n_checks++; if (frame_cmd !== 8'h00) $display("FAIL rst_cmd: %h expected 00", frame_cmd); else n_pass++;
        n_checks++; if (frame_len !== 5'd0) $display("FAIL rst_len: %0d expected 0", frame_len); else n_pass++;
        n_checks++; if (err_code !== 2'd0) $display("FAIL rst_err_code: %0d expected 0", err_code); else n_pass++;
        n_checks++; if (rd_data !== 8'h00) $display("FAIL rst_rd_data: %h expected 00", rd_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: %b expected 0", busy); else n_pass++;
        n_checks++; if (dbg_state !== 3'd0) $display("FAIL rst_state: %0d expected 0", dbg_state); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_good_frame;
        send_byte(8'h55, 1);
        n_checks++; if (busy !== 1'b1) $display("FAIL good_busy_hdr: %b expected 1", busy); else n_pass++;
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        send_byte(8'hA5, 1);
        send_byte(8'h5A, 1);
        n_checks++; if (s_fv !== 1'b0) $display("FAIL good_early_fv: %b expected 0", s_fv); else n_pass++;
        send_byte(8'hFC, 1);
        n_checks++; if (s_fv !== 1'b1) $display("FAIL good_fv: %b expected 1", s_fv); else n_pass++;
        n_checks++; if (s_fe !== 1'b0) $display("FAIL good_fe: %b expected 0", s_fe); else n_pass++;
        n_checks++; if (frame_cmd !== 8'h01) $display("FAIL good_cmd: %h expected 01", frame_cmd); else n_pass++;
        n_checks++; if (frame_len !== 5'd2) $display("FAIL good_len: %0d expected 2", frame_len); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL good_busy_end: %b expected 0", busy); else n_pass++;
        read_byte(4'd0, 8'hA5, "good_rd0");
        read_byte(4'd1, 8'h5A, "good_rd1");
    endtask

    task automatic test_bad_checksum;
        // Correct checksum would be 09^02^A5^5A = F4.
        send_byte(8'h55, 1);
        send_byte(8'h09, 1);
        send_byte(8'h02, 1);
        send_byte(8'hA5, 1);
        send_byte(8'h5A, 1);
        send_byte(8'hF5, 1);
        n_checks++; if (s_fe !== 1'b1) $display("FAIL chk_fe: %b expected 1", s_fe); else n_pass++;
        n_checks++; if (s_fv !== 1'b0) $display("FAIL chk_fv: %b expected 0", s_fv); else n_pass++;
        n_checks++; if (err_code !== 2'd2) $display("FAIL chk_code: %0d expected 2", err_code); else n_pass++;
        n_checks++; if (frame_cmd !== 8'h01) $display("FAIL chk_cmd_held: %h expected 01", frame_cmd); else n_pass++;
        n_checks++; if (frame_len !== 5'd2) $display("FAIL chk_len_held: %0d expected 2", frame_len); else n_pass++;
    endtask

    task automatic test_leading_junk;
        send_byte(8'h00, 1);
        send_byte(8'hFF, 1);
        n_checks++; if (busy !== 1'b0) $display("FAIL junk_busy: %b expected 0", busy); else n_pass++;
        send_byte(8'h55, 1);
        send_byte(8'h07, 1);
        send_byte(8'h00, 1);
        n_checks++; if (dbg_state !== 3'd4) $display("FAIL junk_state: %0d expected 4", dbg_state); else n_pass++;
        send_byte(8'h07, 1);
        n_checks++; if (s_fv !== 1'b1) $display("FAIL junk_fv: %b expected 1", s_fv); else n_pass++;
        n_checks++; if (frame_cmd !== 8'h07) $display("FAIL junk_cmd: %h expected 07", frame_cmd); else n_pass++;
        n_checks++; if (frame_len !== 5'd0) $display("FAIL junk_len: %0d expected 0", frame_len); else n_pass++;
        n_checks++; if (err_code !== 2'd2) $display("FAIL junk_code_held: %0d expected 2", err_code); else n_pass++;
    endtask

    task automatic test_len_limits;
        logic [7:0] chk;
        send_byte(8'h55, 1);
        send_byte(8'h03, 1);
        send_byte(8'h11, 1);
        n_checks++; if (s_fe !== 1'b1) $display("FAIL len_fe: %b expected 1", s_fe); else n_pass++;
        n_checks++; if (err_code !== 2'd1) $display("FAIL len_code: %0d expected 1", err_code); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL len_busy: %b expected 0", busy); else n_pass++;
        // LEN = 16 is the largest accepted payload; bytes are 8'h10 + i.
        chk = 8'h02 ^ 8'h10;
        send_byte(8'h55, 1);
        send_byte(8'h02, 1);
        send_byte(8'h10, 1);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h10 + 8'(i), 1);
            chk = chk ^ (8'h10 + 8'(i));
        end
        send_byte(chk, 1);
        n_checks++; if (s_fv !== 1'b1) $display("FAIL max_fv: %b expected 1", s_fv); else n_pass++;
        n_checks++; if (frame_len !== 5'd16) $display("FAIL max_len: %0d expected 16", frame_len); else n_pass++;
        read_byte(4'd0, 8'h10, "max_rd0");
        read_byte(4'd15, 8'h1F, "max_rd15");
    endtask

    task automatic test_timeout;
        int k;
        send_byte(8'h55, 1);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'h01;
        k = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (i == 1) byte_valid = 1'b0;
            if (frame_err) begin k = i; break; end
        end
        n_checks++; if (k != 201) $display("FAIL to_latency: err at negedge %0d expected 201", k); else n_pass++;
        n_checks++; if (err_code !== 2'd3) $display("FAIL to_code: %0d expected 3", err_code); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL to_busy: %b expected 0", busy); else n_pass++;
        // A strobe landing on the expiry cycle keeps the frame alive.
        send_byte(8'h55, 1);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'h01;
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (199) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'h00;
        @(negedge clk);
        n_checks++; if (frame_err !== 1'b0) $display("FAIL race_fe: %b expected 0", frame_err); else n_pass++;
        n_checks++; if (dbg_state !== 3'd4) $display("FAIL race_state: %0d expected 4", dbg_state); else n_pass++;
        byte_valid = 1'b0;
        send_byte(8'h01, 1);
        n_checks++; if (s_fv !== 1'b1) $display("FAIL race_fv: %b expected 1", s_fv); else n_pass++;
        n_checks++; if (frame_cmd !== 8'h01) $display("FAIL race_cmd: %h expected 01", frame_cmd); else n_pass++;
    endtask

    task automatic test_held_valid;
        // 04 ^ 01 ^ 33 = 36
        send_byte(8'h55, 5);
        send_byte(8'h04, 5);
        send_byte(8'h01, 5);
        send_byte(8'h33, 5);
        send_byte(8'h36, 5);
        n_checks++; if (s_fv !== 1'b1) $display("FAIL held_fv: %b expected 1", s_fv); else n_pass++;
        n_checks++; if (frame_cmd !== 8'h04) $display("FAIL held_cmd: %h expected 04", frame_cmd); else n_pass++;
        n_checks++; if (frame_len !== 5'd1) $display("FAIL held_len: %0d expected 1", frame_len); else n_pass++;
        read_byte(4'd0, 8'h33, "held_rd0");
    endtask

    task automatic test_reset_mid_frame;
        send_byte(8'h55, 1);
        send_byte(8'h05, 1);
        send_byte(8'h03, 1);
        send_byte(8'hAA, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: %b expected 0", busy); else n_pass++;
        n_checks++; if (frame_cmd !== 8'h00) $display("FAIL mid_rst_cmd: %h expected 00", frame_cmd); else n_pass++;
        rst = 1'b0;
        // 06 ^ 01 ^ 77 = 70
        send_byte(8'h55, 1);
        send_byte(8'h06, 1);
        send_byte(8'h01, 1);
        send_byte(8'h77, 1);
        send_byte(8'h70, 1);
        n_checks++; if (s_fv !== 1'b1) $display("FAIL mid_fv: %b expected 1", s_fv); else n_pass++;
        n_checks++; if (frame_cmd !== 8'h06) $display("FAIL mid_cmd: %h expected 06", frame_cmd); else n_pass++;
        n_checks++; if (frame_len !== 5'd1) $display("FAIL mid_len: %0d expected 1", frame_len); else n_pass++;
        read_byte(4'd0, 8'h77, "mid_rd0");
    endtask

    initial begin
        s_fv = 1'b0;
        s_fe = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_leading_junk();
        test_len_limits();
        test_timeout();
        test_held_valid();
        test_reset_mid_frame();
        n_checks++;
        if (n_overlap != 0) $display("FAIL overlap: frame_valid and frame_err together in %0d cycles, expected 0", n_overlap);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
